// File: rtl/startup_sequencer_pkg.sv
// Shared state encoding and width helper for the startup sequencer.
package startup_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    GAP,
    DONE,
    FAULT
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/startup_sequencer_if.sv
// Start/ack inputs and reset/status outputs of the startup sequencer.
interface startup_sequencer_if
  import startup_sequencer_pkg::*;
#(
  parameter int unsigned N_STAGES = 4,
  parameter int unsigned IDX_W    = idx_w(N_STAGES)
);
  logic                start;
  logic [N_STAGES-1:0] stage_ack;
  logic [N_STAGES-1:0] stage_rst;
  logic                done;
  logic                fault;
  logic [IDX_W-1:0]    fault_stage;

  modport master (
    output start, stage_ack,
    input  stage_rst, done, fault, fault_stage
  );

  modport slave (
    input  start, stage_ack,
    output stage_rst, done, fault, fault_stage
  );
endinterface

// File: rtl/startup_sequencer_cycle_timer.sv
// Clearable free-running up-counter with a terminal-count compare.
module cycle_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else              count <= count + CNT_W'(1);
  end

  assign tc = (count == limit);
endmodule

// File: rtl/startup_sequencer.sv
// Releases per-stage resets in order, waiting for each ack plus a settling gap;
// reports completion or a sticky fault naming the stage that failed.
module startup_sequencer
  import startup_sequencer_pkg::*;
#(
  parameter int unsigned N_STAGES       = 4,
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 32
) (
  input logic               clk,
  input logic               rst,
  startup_sequencer_if.slave bus
);
  localparam int unsigned      IDX_W   = idx_w(N_STAGES);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_STAGES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [N_STAGES-1:0] stage_rst_q, stage_rst_next;
  logic                done_q, done_next;
  logic                fault_q, fault_next;
  logic [IDX_W-1:0]    fault_stage_q, fault_stage_next;
  logic                timer_clear, timer_tc;
  logic [CNT_W-1:0]    timer_limit;
  logic                early_lost, any_lost;
  logic [IDX_W-1:0]    early_idx, any_idx;

  // Lowest-index low ack, over all stages and over stages already passed.
  always_comb begin
    early_lost = 1'b0;
    early_idx  = '0;
    any_lost   = 1'b0;
    any_idx    = '0;
    for (int unsigned k = N_STAGES; k > 0; k--) begin
      if (!bus.stage_ack[k-1]) begin
        any_lost = 1'b1;
        any_idx  = IDX_W'(k - 1);
        if ((k - 1) < 32'(idx)) begin
          early_lost = 1'b1;
          early_idx  = IDX_W'(k - 1);
        end
      end
    end
  end

  always_comb begin
    state_next       = state;
    idx_next         = idx;
    fault_stage_next = fault_stage_q;
    if ((state inside {WAIT_ACK, GAP, DONE}) && !bus.start) begin
      state_next = IDLE;
      idx_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state_next = WAIT_ACK;
            idx_next   = '0;
          end
        end
        WAIT_ACK: begin
          if (early_lost) begin
            state_next       = FAULT;
            fault_stage_next = early_idx;
          end else if (bus.stage_ack[idx]) begin
            state_next = (idx == LAST) ? DONE : GAP;
          end else if (timer_tc) begin
            state_next       = FAULT;
            fault_stage_next = idx;
          end
        end
        GAP: begin
          if (early_lost) begin
            state_next       = FAULT;
            fault_stage_next = early_idx;
          end else if (timer_tc) begin
            state_next = WAIT_ACK;
            idx_next   = idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (any_lost) begin
            state_next       = FAULT;
            fault_stage_next = any_idx;
          end
        end
        FAULT:   state_next = FAULT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs are derived from the next state so they can be registered alongside it.
  always_comb begin
    stage_rst_next = '1;
    done_next      = 1'b0;
    fault_next     = 1'b0;
    case (state_next)
      WAIT_ACK, GAP: begin
        for (int unsigned k = 0; k < N_STAGES; k++) begin
          if (k <= 32'(idx_next)) stage_rst_next[k] = 1'b0;
        end
      end
      DONE: begin
        stage_rst_next = '0;
        done_next      = 1'b1;
      end
      FAULT:   fault_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      stage_rst_q   <= '1;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state         <= state_next;
      idx           <= idx_next;
      stage_rst_q   <= stage_rst_next;
      done_q        <= done_next;
      fault_q       <= fault_next;
      fault_stage_q <= fault_stage_next;
    end
  end

  // Timer restarts on every state change so each WAIT_ACK/GAP visit counts from 0.
  always_comb begin
    timer_clear = (state_next != state) || !(state inside {WAIT_ACK, GAP});
    timer_limit = (state == GAP) ? GAP_LIM : TMO_LIM;
  end

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .limit (timer_limit),
    .tc    (timer_tc)
  );

  assign bus.stage_rst   = stage_rst_q;
  assign bus.done        = done_q;
  assign bus.fault       = fault_q;
  assign bus.fault_stage = fault_stage_q;
endmodule

// File: doc/startup_sequencer.md
# startup_sequencer

Power-up reset sequencer sitting directly downstream of the board's power-on delay timer. Once the timer's "delay elapsed" level is high, it releases the per-subsystem resets one stage at a time (clock chips, ADC/DAC interfaces, DSP, host link). Before moving on, it waits for each stage's ready/lock acknowledge plus a fixed settling gap. It reports completion, or a sticky fault naming the stage that failed to acknowledge or lost lock.

## Interface
- N_STAGES, 4: number of sequenced stages (2..16).
- GAP_CYCLES, 1000: settling cycles between a stage's ack and the next release (>=1).
- TIMEOUT_CYCLES, 1000000: max cycles to wait for a stage ack (>=1).
- CNT_W, 32: timer width; must hold max(GAP_CYCLES, TIMEOUT_CYCLES)-1.
- clk  in  1  system clock (same domain as the delay timer).
- rst  in  1  synchronous, active-high reset.
- start  in  1  delay-elapsed level from the power-on timer; high = sequence may run.
- stage_ack  in  N_STAGES  per-stage ready/lock, already synchronous to clk.
- stage_rst  out  N_STAGES  per-stage reset, active-high, registered.
- done  out  1  all stages released and acknowledged, registered.
- fault  out  1  sticky failure flag, registered.
- fault_stage  out  IDX_W  index of the failing stage, where IDX_W = max(1, clog2(N_STAGES)).

## Operation
- Reset values:
  - stage_rst = all ones; done = 0; fault = 0; fault_stage = 0.
  - State IDLE; stage index i = 0; timer = 0.
- IDLE: start high -> RELEASE of stage 0.
- RELEASE/WAIT_ACK:
  - stage_rst[i] cleared; timer cleared; then wait for stage_ack[i].
  - Ack seen -> GAP, or DONE if i = N_STAGES-1.
  - Timer reaches TIMEOUT_CYCLES-1 with no ack -> FAULT.
- GAP: timer counts up from 0; at GAP_CYCLES-1, i increments and stage i is released.
- DONE: done = 1. Any stage_ack[k] falling -> FAULT with fault_stage = lowest such k.
- FAULT:
  - All stage_rst reasserted; done = 0; fault = 1; fault_stage latched.
  - Sticky until rst; start is ignored in FAULT.
- Abort: start low in any state other than IDLE or FAULT:
  - All stage_rst reasserted; done cleared; i = 0; return to IDLE.
  - A later start high restarts the sequence from stage 0.
- Released stages stay released (stage_rst[k] = 0 for k < i) until abort or FAULT.
- During WAIT_ACK/GAP, ack of an earlier stage dropping -> FAULT with that stage index.
- Priority, highest first: rst > abort (start low) > fault detection > ack/timer progress.
- Ack in the same cycle as timeout terminal count -> ack wins, no fault.

## Timing
- start sampled high in cycle 0 -> stage_rst[0] = 0 in cycle 1; WAIT_ACK timer = 0 in cycle 1.
- Ack timing, with stage_ack[i] first high in cycle t during WAIT_ACK:
  - GAP entered in t+1.
  - stage_rst[i+1] = 0 in cycle t+1+GAP_CYCLES.
- Last-stage ack high in cycle t -> done = 1 in cycle t+1.
- WAIT_ACK entered in cycle w with ack low through w+TIMEOUT_CYCLES-1:
  - fault = 1 and stage_rst all ones in cycle w+TIMEOUT_CYCLES.
- Abort: start low in cycle a -> stage_rst all ones and done = 0 in cycle a+1.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Shared package/include:
  - FSM state encodings: IDLE, WAIT_ACK, GAP, DONE, FAULT (RELEASE is folded into the transition).
  - IDX_W derivation function.
- One natural sub-module: cycle_timer, a clearable up-counter with terminal-count compare.
  - Used by both GAP and WAIT_ACK: a single instance, limit muxed by state.

## Test plan
Bench parameters: N_STAGES=4, GAP_CYCLES=8, TIMEOUT_CYCLES=32.
- Nominal: start high at cycle 0; each ack raised 3 cycles after its release -> releases at cycles 1, 13, 25, 37; done = 1 at cycle 41; fault stays 0.
- Timeout: stage 2 ack never rises -> fault = 1 and fault_stage = 2 exactly 32 cycles after stage_rst[2] fell; stage_rst = 4'b1111.
- Tie: stage 1 ack rises exactly on its timeout terminal cycle -> no fault; sequence continues.
- Lock loss: in DONE, drop stage_ack[1] and stage_ack[3] together -> next cycle fault = 1, fault_stage = 1, done = 0, all resets asserted.
- Abort: start low during stage-2 GAP -> next cycle all resets asserted, state IDLE; start high again -> full sequence repeats from stage 0.
- Reset: rst pulsed in DONE and again in FAULT -> all outputs return to reset values the following cycle; FAULT is not exited by start alone.
